// File: rtl/qam_pkg.sv
// Shared types and constants for the QAM symbol deframer.
package qam_pkg;

    localparam int SYM_W  = 4;
    localparam int BYTE_W = 8;

    localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hEB90;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD
    } state_t;

    function automatic logic [BYTE_W-1:0] pack_byte(input logic [SYM_W-1:0] first,
                                                    input logic [SYM_W-1:0] second);
        return {first, second};
    endfunction

endpackage

// File: rtl/qam_byte_fifo.sv
// Small synchronous FIFO holding {last, byte} entries for the deframer output.
// The head reads as zero while empty so the AXI-Stream payload is clean after reset.
module qam_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    // A pop on the same edge frees the slot, so a write into a full FIFO still lands.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/qam_deframer.sv
// Recovers length-prefixed byte frames from a 4-bit symbol stream and emits them on AXI-Stream.
// Define QAM_DEFRAMER_STATS_EN to build the frame_cnt / drop_cnt statistics counters.
module qam_deframer
    import qam_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD  = DEFAULT_SYNC_WORD,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic              axi_clk,
    input  logic              axi_rstn,
    input  logic              sym_valid,
    input  logic [SYM_W-1:0]  sym,
    output logic [BYTE_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              in_frame,
    output logic              overflow,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        drop_cnt
);
    state_t             state;
    logic [15:0]        history;
    logic [SYM_W-1:0]   first_nib;
    logic               second_phase;
    logic [7:0]         remaining;
    logic [BYTE_W-1:0]  pair_byte;
    logic               sync_hit;
    logic               byte_done;
    logic               pop;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [BYTE_W:0]    fifo_dout;

    assign pair_byte = pack_byte(first_nib, sym);
    assign sync_hit  = sym_valid && ({history[11:0], sym} == SYNC_WORD);
    assign byte_done = sym_valid && (state == ST_PAYLOAD) && second_phase;
    assign pop       = m_axis_tvalid && m_axis_tready;
    assign drop      = byte_done && fifo_full && !pop;

    qam_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W + 1)
    ) u_fifo (
        .clk     (axi_clk),
        .rst_n   (axi_rstn),
        .wr_en   (byte_done),
        .wr_data ({remaining == 8'd1, pair_byte}),
        .rd_en   (m_axis_tready),
        .rd_data (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tlast  = fifo_dout[BYTE_W];
    assign m_axis_tdata  = fifo_dout[BYTE_W-1:0];

    // Sync search only runs in HUNT; a dropped byte still consumes length so framing stays aligned.
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state        <= ST_HUNT;
            history      <= '0;
            first_nib    <= '0;
            second_phase <= 1'b0;
            remaining    <= '0;
            in_frame     <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end
            if (sym_valid) begin
                history <= {history[11:0], sym};
                case (state)
                    ST_HUNT: begin
                        second_phase <= 1'b0;
                        if (sync_hit) begin
                            state    <= ST_LEN;
                            in_frame <= 1'b1;
                        end
                    end
                    ST_LEN: begin
                        if (!second_phase) begin
                            first_nib    <= sym;
                            second_phase <= 1'b1;
                        end else begin
                            second_phase <= 1'b0;
                            if (pair_byte == 8'd0) begin
                                state    <= ST_HUNT;
                                in_frame <= 1'b0;
                            end else begin
                                state     <= ST_PAYLOAD;
                                remaining <= pair_byte;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (!second_phase) begin
                            first_nib    <= sym;
                            second_phase <= 1'b1;
                        end else begin
                            second_phase <= 1'b0;
                            remaining    <= remaining - 8'd1;
                            if (remaining == 8'd1) begin
                                state    <= ST_HUNT;
                                in_frame <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state    <= ST_HUNT;
                        in_frame <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef QAM_DEFRAMER_STATS_EN
    logic        frame_done;
    logic [15:0] frame_q;
    logic [7:0]  drop_q;

    assign frame_done = sym_valid && second_phase &&
                        (((state == ST_LEN) && (pair_byte == 8'd0)) ||
                         ((state == ST_PAYLOAD) && (remaining == 8'd1)));

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            frame_q <= '0;
            drop_q  <= '0;
        end else begin
            if (frame_done) begin
                frame_q <= frame_q + 16'd1;
            end
            if (drop && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign frame_cnt = frame_q;
    assign drop_cnt  = drop_q;
`else
    assign frame_cnt = '0;
    assign drop_cnt  = '0;
`endif

endmodule

// File: doc/qam_deframer.md
QAM_DEFRAMER -- requirements
Module: qam_deframer

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 16'hEB90, 4-symbol frame sync pattern (first symbol = bits 15:12).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, output byte buffer entries (power of 2, >=2).
REQ-003 SHALL have port axi_clk  in  1  single clock; all logic rising-edge.
REQ-004 SHALL have port axi_rstn  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port sym_valid  in  1  one-cycle strobe per demodulated symbol.
REQ-006 SHALL have port sym  in  4  Gray-coded demodulated symbol, {Q[1:0],I[1:0]}.
REQ-007 SHALL have port m_axis_tdata  out  8  payload byte.
REQ-008 SHALL have port m_axis_tvalid  out  1  byte available.
REQ-009 SHALL have port m_axis_tready  in  1  downstream accepts.
REQ-010 SHALL have port m_axis_tlast  out  1  last payload byte of frame.
REQ-011 SHALL have port in_frame  out  1  high in LEN or PAYLOAD state.
REQ-012 SHALL have port overflow  out  1  sticky, byte dropped due to full FIFO.
REQ-013 SHALL have ports frame_cnt  out  16 and drop_cnt  out  8, statistics (see Configuration).

Function
REQ-014 SHALL shift sym into a 16-bit history register on every sym_valid, newest symbol in bits 3:0, regardless of state.
REQ-015 SHALL implement states HUNT, LEN, PAYLOAD; only sym_valid cycles advance state.
REQ-016 In HUNT, SHALL go to LEN when {history[11:0],sym}==SYNC_WORD on a sym_valid cycle.
REQ-017 In LEN, SHALL capture two symbols as length byte {first,second}; len==0 -> HUNT, frame counted, no output; else -> PAYLOAD, remaining=len.
REQ-018 In PAYLOAD, SHALL pack each symbol pair into a byte {first,second}, write {last,byte} to FIFO on the edge sampling the second symbol, last=1 when remaining==1; after last byte -> HUNT.
REQ-019 SHALL not search for SYNC_WORD while in LEN or PAYLOAD.
REQ-020 m_axis_tvalid SHALL be FIFO not-empty; tdata/tlast SHALL be the FIFO head; first byte visible the cycle after its write edge (latency 1 cycle from second-nibble strobe).
REQ-021 Head SHALL pop only when tvalid && tready; tdata/tlast SHALL be stable while tvalid && !tready.
REQ-022 Write when full without simultaneous pop SHALL drop the byte, set overflow, and still advance remaining/state.
REQ-023 Simultaneous write and pop when full SHALL both succeed, no overflow.
REQ-024 Width: remaining SHALL be 8 bits; FIFO pointers log2(FIFO_DEPTH)+1 bits, wrap naturally.

Reset
REQ-025 On axi_rstn low SHALL clear immediately: state=HUNT, history=0, FIFO empty, tvalid=0, tdata=0, tlast=0, in_frame=0, overflow=0, frame_cnt=0, drop_cnt=0.
REQ-026 Reset mid-frame SHALL discard the partial frame and buffered bytes; after release hunting restarts.

Configuration
REQ-027 With QAM_DEFRAMER_STATS_EN defined, frame_cnt SHALL increment (wrapping) on each completed frame (last byte processed or len==0), drop_cnt SHALL increment per dropped byte, saturating at 255.
REQ-028 Without QAM_DEFRAMER_STATS_EN, frame_cnt and drop_cnt SHALL be tied to 0 and no counter logic synthesised.

Structure
REQ-029 Package qam_pkg SHALL hold the state enum type, default SYNC_WORD constant, and symbol/byte width constants.
REQ-030 FIFO SHALL be a sub-module qam_byte_fifo (9-bit entries, full/empty, synchronous write/pop, async active-low reset).

Verification
REQ-031 Symbols E,B,9,0,0,2,A,5,3,C with tready=1 -> bytes 8'hA5 (tlast=0), 8'h3C (tlast=1), frame_cnt=1, in_frame low after last.
REQ-032 Symbols E,B,9,0,0,0 -> no output, state HUNT, frame_cnt=1.
REQ-033 Sync, len=6, tready=0, FIFO_DEPTH=4 -> 4 bytes held, 2 dropped, overflow=1, drop_cnt=2, tlast byte lost.
REQ-034 Payload containing E,B,9,0 mid-frame -> treated as data, no resync; resync only after tlast.
REQ-035 axi_rstn pulse after length byte of len=3 frame -> outputs zero immediately, next valid frame received correctly.
REQ-036 Full FIFO with tready=1 and simultaneous write -> byte accepted, overflow stays 0, order preserved.
